// File: rtl/sseg_pkg.sv
// Shared constants, digit-select type and hex-to-segment decode for the
// seven-segment scan driver.
package sseg_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;

   typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} dig_sel_t;

   // Active-low cathodes {dp,g,f,e,d,c,b,a}; DP held off
   function automatic logic [7:0] hex_decode(input logic [3:0] d);
      logic [7:0] s;
      s = SEG_BLANK;
      case (d)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         4'hF: s = 8'h8E;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin2bcd_16.sv
// Iterative double-dabble converter: 16 add-3/shift steps, one per cycle.
// done pulses in the last SHIFT cycle with bcd carrying the final result.
module bin2bcd_16 (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        start,
   input  logic [15:0] bin,
   output logic        busy,
   output logic        done,
   output logic [15:0] bcd,
   output logic        ovf
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

   conv_state_t state, state_next;
   logic [15:0] bin_sr;
   logic [15:0] bcd_sr;
   logic [15:0] adj;
   logic [31:0] stepped;
   logic [3:0]  iter;
   logic        ovf_r;

   always_comb begin
      adj = bcd_sr;
      for (int unsigned i = 0; i < 4; i++) begin
         if (bcd_sr[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      end
      stepped = {adj, bin_sr} << 1;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SHIFT;
         SHIFT:   if (!start && iter == 4'd15) state_next = DONE;
         DONE:    state_next = start ? SHIFT : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state  <= IDLE;
         bin_sr <= '0;
         bcd_sr <= '0;
         iter   <= '0;
         ovf_r  <= 1'b0;
      end else begin
         state <= state_next;
         if (start) begin
            bin_sr <= bin;
            bcd_sr <= '0;
            iter   <= '0;
            ovf_r  <= (bin > 16'd9999);
         end else if (state == SHIFT) begin
            {bcd_sr, bin_sr} <= stepped;
            iter             <= iter + 4'd1;
         end
      end
   end

   // A restart in the final cycle discards the superseded result
   assign busy = (state == SHIFT);
   assign done = (state == SHIFT) && (iter == 4'd15) && !start;
   assign bcd  = stepped[31:16];
   assign ovf  = ovf_r;

endmodule

// File: rtl/sseg_scan_driver.sv
// Basys3 4-digit seven-segment driver: hex or decimal display of a 16-bit
// value, anode time-multiplexing and optional leading-zero blanking.
module sseg_scan_driver
   import sseg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 25000,
   parameter int unsigned SIM_FAST    = 0
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] DATA_IN,
   input  logic        DATA_WE,
   input  logic        HEX_MODE,
   input  logic        BLANK_LZ,
   output logic [7:0]  SEGS,
   output logic [3:0]  AN,
   output logic        BUSY
);

   // SIM_FAST is kept only for interface compatibility
   localparam int unsigned DIV   = (SIM_FAST != 0) ? REFRESH_DIV : REFRESH_DIV;
   localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] refresh_cnt;
   dig_sel_t         scan_idx;
   logic [15:0]      digit_r;
   logic             dash_r;
   logic             mode_hex;
   logic             blank_lz_r;

   logic             hex_load;
   logic             dec_start;
   logic             conv_reset;
   logic             conv_busy;
   logic             conv_done;
   logic [15:0]      conv_bcd;
   logic             conv_ovf;

   logic [3:0]       sel_digit;
   logic [3:0]       zero_from;
   logic             show_dash;
   logic             blanked;
   logic [7:0]       segs_next;
   logic [3:0]       an_next;

   assign hex_load   = DATA_WE & HEX_MODE;
   assign dec_start  = DATA_WE & ~HEX_MODE;
   // A hex load aborts any conversion in flight
   assign conv_reset = RESET | hex_load;

   bin2bcd_16 u_conv (
      .CLK   (CLK),
      .RESET (conv_reset),
      .start (dec_start),
      .bin   (DATA_IN),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd),
      .ovf   (conv_ovf)
   );

   assign BUSY = conv_busy;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         refresh_cnt <= '0;
         scan_idx    <= DIG0;
      end else if (refresh_cnt == CNT_W'(DIV - 1)) begin
         refresh_cnt <= '0;
         scan_idx    <= dig_sel_t'(scan_idx + 2'd1);
      end else begin
         refresh_cnt <= refresh_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         digit_r    <= '0;
         dash_r     <= 1'b0;
         mode_hex   <= 1'b1;
         blank_lz_r <= 1'b0;
      end else begin
         if (DATA_WE) begin
            mode_hex   <= HEX_MODE;
            blank_lz_r <= BLANK_LZ;
         end
         if (hex_load) begin
            digit_r <= DATA_IN;
            dash_r  <= 1'b0;
         end else if (conv_done) begin
            digit_r <= conv_bcd;
            dash_r  <= conv_ovf;
         end
      end
   end

   always_comb begin
      zero_from[3] = (digit_r[15:12] == 4'd0);
      zero_from[2] = zero_from[3] & (digit_r[11:8] == 4'd0);
      zero_from[1] = zero_from[2] & (digit_r[7:4]  == 4'd0);
      zero_from[0] = zero_from[1] & (digit_r[3:0]  == 4'd0);

      case (scan_idx)
         DIG0:    sel_digit = digit_r[3:0];
         DIG1:    sel_digit = digit_r[7:4];
         DIG2:    sel_digit = digit_r[11:8];
         DIG3:    sel_digit = digit_r[15:12];
         default: sel_digit = digit_r[3:0];
      endcase

      show_dash = dash_r & ~mode_hex;
      blanked   = blank_lz_r && !show_dash && (scan_idx != DIG0) && zero_from[scan_idx];

      an_next   = ~(4'b0001 << scan_idx);
      segs_next = show_dash ? SEG_DASH : hex_decode(sel_digit);
      if (blanked) begin
         an_next   = 4'hF;
         segs_next = SEG_BLANK;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         SEGS <= SEG_BLANK;
         AN   <= 4'hF;
      end else begin
         SEGS <= segs_next;
         AN   <= an_next;
      end
   end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed plus randomized bench for sseg_scan_driver against a cycle-level
// model built from digit values, pending-conversion countdown and scan slot.
module tb_sseg_scan_driver;

   localparam int unsigned DIV = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] din;
   logic        we;
   logic        hexm;
   logic        blz;
   logic [7:0]  segs;
   logic [3:0]  an;
   logic        busy;

   always #5 clk = ~clk;

   sseg_scan_driver #(.REFRESH_DIV(DIV), .SIM_FAST(1)) dut (
      .CLK      (clk),
      .RESET    (rst),
      .DATA_IN  (din),
      .DATA_WE  (we),
      .HEX_MODE (hexm),
      .BLANK_LZ (blz),
      .SEGS     (segs),
      .AN       (an),
      .BUSY     (busy)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Model: digit values held by the display, dash/blank flags, pending conversion
   int unsigned m_dig [4];
   bit          m_dash;
   bit          m_blank;
   bit          pend;
   int unsigned pend_val;
   int          pend_left;
   int          cyc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_display(input int slot, output logic [3:0] ean, output logic [7:0] eseg);
      bit lz;
      lz = 1'b1;
      for (int i = slot; i < 4; i++) if (m_dig[i] != 0) lz = 1'b0;
      ean  = ~(4'b0001 << slot);
      eseg = seg_tab[m_dig[slot]];
      if (m_dash) begin
         eseg = 8'hBF;
      end else if (m_blank && slot > 0 && lz) begin
         ean  = 4'hF;
         eseg = 8'hFF;
      end
   endtask

   task automatic commit(input int unsigned v);
      if (v > 9999) begin
         m_dash = 1'b1;
      end else begin
         m_dash   = 1'b0;
         m_dig[0] = v % 10;
         m_dig[1] = (v / 10) % 10;
         m_dig[2] = (v / 100) % 10;
         m_dig[3] = v / 1000;
      end
   endtask

   task automatic step(input bit r, input bit w, input bit h, input bit b, input logic [15:0] d);
      logic [3:0] e_an;
      logic [7:0] e_seg;
      rst = r; we = w; hexm = h; blz = b; din = d;
      @(posedge clk);
      if (r) begin
         e_an = 4'hF; e_seg = 8'hFF;
         for (int i = 0; i < 4; i++) m_dig[i] = 0;
         m_dash = 0; m_blank = 0; pend = 0; pend_left = 0; cyc = 0;
      end else begin
         model_display((cyc / DIV) % 4, e_an, e_seg);
         cyc++;
         if (w && h) begin
            for (int i = 0; i < 4; i++) m_dig[i] = (d >> (4 * i)) & 16'hF;
            m_dash = 0;
            pend   = 0;
         end else if (w) begin
            pend = 1; pend_val = d; pend_left = 16;
         end else if (pend) begin
            pend_left--;
            if (pend_left == 0) begin
               pend = 0;
               commit(pend_val);
            end
         end
         if (w) m_blank = b;
      end
      #1;
      check("AN", 32'(an), 32'(e_an));
      check("SEGS", 32'(segs), 32'(e_seg));
      check("BUSY", 32'(busy), 32'(pend));
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(0, 0, 1'($urandom), 1'($urandom), 16'($urandom));
   endtask

   initial begin
      rst = 1; we = 0; hexm = 1; blz = 0; din = '0; cyc = 0;
      @(negedge clk);
      step(1, 0, 0, 0, 16'h0);
      step(1, 0, 0, 0, 16'h0);

      // Scan from reset: all slots show 0
      idle(20);

      // Hex load
      step(0, 1, 1, 0, 16'hA5F0);
      idle(20);

      // Decimal load and busy window
      step(0, 1, 0, 0, 16'd1234);
      idle(36);

      // Overflow dashes, then max decimal
      step(0, 1, 0, 0, 16'd10000);
      idle(36);
      step(0, 1, 0, 0, 16'd9999);
      idle(36);

      // Restart during conversion with leading-zero blanking
      step(0, 1, 0, 1, 16'd42);
      idle(4);
      step(0, 1, 0, 1, 16'd7);
      idle(36);
      check("SLOT0_AFTER_RESTART", 32'(m_dig[0]), 32'd7);

      // Reset asserted on the 8th busy cycle
      step(0, 1, 0, 0, 16'd5678);
      idle(7);
      step(1, 0, 0, 0, 16'h0);
      idle(20);

      // Randomized loads, including writes during busy and hex aborts
      for (int k = 0; k < 150; k++) begin
         logic [15:0] v;
         bit          h;
         idle($urandom_range(0, 22));
         h = ($urandom_range(0, 2) == 0);
         if (h)
            v = 16'($urandom);
         else if ($urandom_range(0, 3) == 0)
            v = 16'($urandom);
         else
            v = 16'($urandom_range(0, 9999));
         if ($urandom_range(0, 2) == 0 && !h) v = 16'($urandom_range(0, 99));
         step(0, 1, h, 1'($urandom), v);
      end
      idle(40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Downstream consumer of the wrapper's memory-mapped output path. Software writes one 16-bit value; this block drives the Basys3 4-digit seven-segment display in place of raw segment/anode port registers.
- Shows the value as 4 hex digits, or as decimal (0–9999) through an internal iterative binary-to-BCD converter.
- Time-multiplexes the anodes at a parameterised refresh rate, with optional leading-zero blanking.

Parameters:
- REFRESH_DIV, 25000, CLK cycles each digit stays lit before the scan advances; minimum 2.
- SIM_FAST, 0, unused by logic; the bench overrides REFRESH_DIV instead.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- DATA_IN  in  16  value to display
- DATA_WE  in  1  one-cycle load strobe; samples DATA_IN, HEX_MODE and BLANK_LZ
- HEX_MODE  in  1  1 = hex digits, 0 = decimal
- BLANK_LZ  in  1  1 = blank leading zero digits
- SEGS  out  8  cathodes, active low; [7]=DP, [6:0]={g,f,e,d,c,b,a}
- AN  out  4  anodes, active low; AN[0] = rightmost digit
- BUSY  out  1  decimal conversion in progress

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high and overrides all other activity.
- Reset values: SEGS=8'hFF, AN=4'hF, BUSY=0, digit registers=0, scan index=0, refresh counter=0, mode=hex, blanking off.
- Refresh counter: counts 0..REFRESH_DIV-1.
  - On the terminal count it wraps to 0 and the scan index advances 0→1→2→3→0.
- Output registers: SEGS and AN are registered from the scan index and the digit registers every cycle.
  - One cycle latency.
  - The first cycle after reset release gives AN=4'b1110, SEGS=8'hC0.
- DP: always off (SEGS[7]=1).
- Hex load: on DATA_WE with HEX_MODE=1, digit[i] = DATA_IN[4i+3:4i] in the next cycle. Any conversion in progress is aborted and BUSY drops.
- Decimal load: on DATA_WE (cycle N) with HEX_MODE=0, the converter starts.
  - BUSY=1 for cycles N+1..N+16 (double-dabble, one shift per cycle).
  - The digit registers update together at the end of N+16. Old digits stay displayed until then, with no partial values.
- Decimal overflow: DATA_IN > 9999 makes every digit show a dash (SEGS=8'hBF) once the conversion completes.
- DATA_WE while BUSY: restarts the conversion with the new value. The latest write wins, and BUSY stays high for 16 cycles from the restart.
- Decode, 0..F: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
- Leading-zero blanking (BLANK_LZ=1):
  - A digit i>0 is blanked if it and all higher digits are 0.
  - A blanked slot drives AN=4'hF and SEGS=8'hFF; the scan timing is unchanged.
  - Digit 0 is never blanked.
  - Dash display is never blanked.
- Reset mid-conversion: the conversion is aborted and the reset values apply the next cycle.
- Refresh and scan keep running independently of loads and conversion.

Decomposition:
- Package sseg_pkg:
  - SEG_BLANK=8'hFF, SEG_DASH=8'hBF
  - the 16-entry hex decode constant array, or a decode function
  - a digit-select enum (DIG0..DIG3)
- Sub-module bin2bcd_16: iterative double-dabble converter.
  - Ports: CLK, RESET, start, bin[15:0], busy, done (1-cycle pulse), bcd[15:0], ovf.
  - Internal FSM: IDLE → SHIFT (16 iterations, add-3 correction before each shift) → DONE → IDLE.
  - A start in any state reloads the converter and enters SHIFT.
- The top level holds the refresh counter, scan index, digit/mode registers, blanking logic and output registers.

Test Plan:
1. Reset, REFRESH_DIV=4. Release reset → AN cycles 1110,1101,1011,0111 with 4 cycles per digit, SEGS=C0 throughout, BUSY=0.
2. Hex load: DATA_IN=16'hA5F0, HEX_MODE=1, pulse WE → digit slots 0..3 show C0,8E,92,88; BUSY never asserts.
3. Decimal load: DATA_IN=1234, HEX_MODE=0, pulse at cycle N → BUSY high exactly N+1..N+16; from N+17 the slots show 99,B0,A4,F9; previous digits shown up to N+16.
4. Overflow: decimal DATA_IN=10000 → all four slots SEGS=BF after the conversion; DATA_IN=9999 → 90 in all slots.
5. Restart and blanking: decimal 42, then a second WE with 7 at 5 cycles later, BLANK_LZ=1 → BUSY continuous until 16 cycles after the second WE; slot 0 shows F8; slots 1–3 give AN=F, SEGS=FF; value 42 is never displayed.
6. Reset mid-conversion: RESET asserted at the 8th BUSY cycle → next cycle BUSY=0, AN=F, SEGS=FF, digits=0; after release the display shows 0.
